// File: rtl/instruction_fetch.sv
// Instruction fetch stage: computes the next PC for the external PC register and
// fetches one instruction per cycle into a single-entry slot feeding decode.
module instruction_fetch #(
    parameter int          ADDR_W     = 32,
    parameter int          INSTR_W    = 32,
    parameter int unsigned INT_VECTOR = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  programCounter,
    output logic [ADDR_W-1:0]  address,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    input  logic               decode_stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               interrupt,
    output logic               int_ack,
    output logic [ADDR_W-1:0]  epc
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        IRQ
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instruction_q, instruction_d;
    logic               instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0]  epc_q, epc_d;
    logic               interrupt_q;

    logic irq_edge;
    logic consume;
    logic slot_free;

    assign irq_edge  = interrupt & ~interrupt_q;
    assign consume   = instr_valid_q & ~decode_stall;
    assign slot_free = ~instr_valid_q | consume;

    // Interrupt entry outranks a branch, which outranks the normal fetch path.
    always_comb begin
        state_d       = state_q;
        instruction_d = instruction_q;
        instr_valid_d = instr_valid_q;
        epc_d         = epc_q;
        address       = programCounter;
        imem_req      = 1'b0;
        int_ack       = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH, HOLD: begin
                if (state_q == FETCH) begin
                    imem_req = slot_free;
                end
                if (irq_edge) begin
                    address       = ADDR_W'(INT_VECTOR);
                    epc_d         = branch_taken ? branch_target : programCounter;
                    instr_valid_d = 1'b0;
                    state_d       = IRQ;
                end else if (branch_taken) begin
                    address       = branch_target;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (state_q == HOLD) begin
                    if (!decode_stall) begin
                        instr_valid_d = 1'b0;
                        state_d       = FETCH;
                    end
                end else if (instr_valid_q && decode_stall) begin
                    state_d = HOLD;
                end else if (slot_free && imem_ready) begin
                    instruction_d = imem_data;
                    instr_valid_d = 1'b1;
                    address       = programCounter + ADDR_W'(1);
                end else if (consume) begin
                    instr_valid_d = 1'b0;
                end
            end
            IRQ: begin
                int_ack = 1'b1;
                state_d = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The PC register is also in reset, so present its reset-time input as zero.
        if (reset) begin
            address = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            instruction_q <= '0;
            instr_valid_q <= 1'b0;
            epc_q         <= '0;
            interrupt_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            instruction_q <= instruction_d;
            instr_valid_q <= instr_valid_d;
            epc_q         <= epc_d;
            interrupt_q   <= interrupt;
        end
    end

    assign imem_addr   = programCounter;
    assign instruction = instruction_q;
    assign instr_valid = instr_valid_q;
    assign epc         = epc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised and directed bench for instruction_fetch; the bench also plays the PC
// register, loading the model's predicted next PC on every clock edge.
module tb_instruction_fetch;

    localparam logic [31:0] INT_VEC = 32'd8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] programCounter;
    logic [31:0] address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        decode_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        interrupt;
    logic        int_ack;
    logic [31:0] epc;

    always #5 clock = ~clock;

    instruction_fetch #(
        .ADDR_W(32),
        .INSTR_W(32),
        .INT_VECTOR(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .programCounter(programCounter),
        .address(address),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ready(imem_ready),
        .imem_data(imem_data),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .decode_stall(decode_stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .interrupt(interrupt),
        .int_ack(int_ack),
        .epc(epc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] epc;
        logic        req;
        logic        ack;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    // Reference model: a one-word slot, a "decode is holding the word" flag,
    // a "startup cycle done" flag and an "acknowledge due" flag.
    logic [31:0] m_instr, m_epc, n_instr, n_epc;
    logic        m_valid, m_started, m_ackdue, m_held, m_intprev;
    logic        n_valid, n_started, n_ackdue, n_held, n_intprev;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_instr   = '0;
        m_epc     = '0;
        m_valid   = 1'b0;
        m_started = 1'b0;
        m_ackdue  = 1'b0;
        m_held    = 1'b0;
        m_intprev = 1'b0;
    endtask

    task automatic modelEval();
        logic irq_rise;
        logic taken_by_decode;
        cur.pc    = programCounter;
        cur.instr = m_instr;
        cur.valid = m_valid;
        cur.epc   = m_epc;
        cur.req   = 1'b0;
        cur.ack   = 1'b0;
        cur.addr  = programCounter;
        n_instr   = m_instr;
        n_epc     = m_epc;
        n_valid   = m_valid;
        n_started = m_started;
        n_ackdue  = m_ackdue;
        n_held    = m_held;
        n_intprev = interrupt;
        if (!m_started) begin
            n_started = 1'b1;
        end else if (m_ackdue) begin
            cur.ack  = 1'b1;
            n_ackdue = 1'b0;
        end else begin
            irq_rise        = interrupt && !m_intprev;
            taken_by_decode = m_valid && !decode_stall;
            cur.req         = !m_held && (!m_valid || taken_by_decode);
            if (irq_rise) begin
                cur.addr = INT_VEC;
                n_epc    = branch_taken ? branch_target : programCounter;
                n_valid  = 1'b0;
                n_held   = 1'b0;
                n_ackdue = 1'b1;
            end else if (branch_taken) begin
                cur.addr = branch_target;
                n_valid  = 1'b0;
                n_held   = 1'b0;
            end else if (m_held) begin
                if (!decode_stall) begin
                    n_valid = 1'b0;
                    n_held  = 1'b0;
                end
            end else if (m_valid && decode_stall) begin
                n_held = 1'b1;
            end else if (cur.req && imem_ready) begin
                n_instr  = imem_data;
                n_valid  = 1'b1;
                cur.addr = programCounter + 32'd1;
            end else if (taken_by_decode) begin
                n_valid = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input logic stall, input logic ready, input logic br,
                                 input logic [31:0] tgt, input logic intr,
                                 input logic pc_data);
        decode_stall  = stall;
        imem_ready    = ready;
        branch_taken  = br;
        branch_target = tgt;
        interrupt     = intr;
        imem_data     = pc_data ? (32'hA000_0000 + programCounter) : $urandom;
        #1;
        modelEval();
        exp_q.push_back(cur);
    endtask

    task automatic stepClock();
        @(posedge clock);
        #1;
        m_instr        = n_instr;
        m_epc          = n_epc;
        m_valid        = n_valid;
        m_started      = n_started;
        m_ackdue       = n_ackdue;
        m_held         = n_held;
        m_intprev      = n_intprev;
        programCounter = cur.addr;
    endtask

    task automatic doReset(input logic [31:0] pc_init);
        reset          = 1'b1;
        programCounter = pc_init;
        modelReset();
        #1;
        checkOutput("rst_address", address, 32'h0);
        checkOutput("rst_imem_req", {31'b0, imem_req}, 32'h0);
        checkOutput("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("rst_int_ack", {31'b0, int_ack}, 32'h0);
        checkOutput("rst_instruction", instruction, 32'h0);
        checkOutput("rst_epc", epc, 32'h0);
        decode_stall  = 1'b0;
        imem_ready    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        interrupt     = 1'b0;
        imem_data     = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    // Scoreboard monitor: compares every cycle that has a prediction queued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_address", address, e.addr);
                checkOutput("sb_imem_addr", imem_addr, e.pc);
                checkOutput("sb_imem_req", {31'b0, imem_req}, {31'b0, e.req});
                checkOutput("sb_int_ack", {31'b0, int_ack}, {31'b0, e.ack});
                checkOutput("sb_instr_valid", {31'b0, instr_valid}, {31'b0, e.valid});
                checkOutput("sb_instruction", instruction, e.instr);
                checkOutput("sb_epc", epc, e.epc);
            end
        end
    end

    initial begin
        int   ack_count;
        logic intr_level;
        reset          = 1'b1;
        programCounter = '0;
        decode_stall   = 1'b0;
        imem_ready     = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = '0;
        interrupt      = 1'b0;
        imem_data      = '0;

        $display("[TB] sequential fetch from PC 14");
        doReset(32'd14);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("seq_idle_addr", address, 32'd14);
        checkOutput("seq_idle_req", {31'b0, imem_req}, 32'h0);
        stepClock();
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("seq_addr15", address, 32'd15);
        checkOutput("seq_req", {31'b0, imem_req}, 32'h1);
        stepClock();
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("seq_addr16", address, 32'd16);
        checkOutput("seq_instr_e", instruction, 32'hA000_000E);
        checkOutput("seq_valid", {31'b0, instr_valid}, 32'h1);
        stepClock();
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("seq_addr17", address, 32'd17);
        checkOutput("seq_instr_f", instruction, 32'hA000_000F);
        stepClock();

        $display("[TB] PC wrap at all-ones");
        doReset(32'hFFFF_FFFF);
        applyStimulus(0, 1, 0, 0, 0, 1);
        stepClock();
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("wrap_addr", address, 32'h0);
        stepClock();

        $display("[TB] decode stall hold");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 1);
            checkOutput("stall_req", {31'b0, imem_req}, 32'h0);
            checkOutput("stall_addr", address, 32'h0);
            checkOutput("stall_instr", instruction, 32'h9FFF_FFFF);
            stepClock();
        end
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("release_req", {31'b0, imem_req}, 32'h0);
        stepClock();
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("resume_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("resume_req", {31'b0, imem_req}, 32'h1);
        stepClock();

        $display("[TB] branch redirect discards response");
        applyStimulus(0, 1, 1, 32'd20, 0, 1);
        stepClock();
        applyStimulus(0, 1, 1, 32'd40, 0, 1);
        checkOutput("br_addr", address, 32'd40);
        stepClock();
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("br_flush_valid", {31'b0, instr_valid}, 32'h0);
        checkOutput("br_instr_kept", instruction, 32'hA000_0000);
        checkOutput("br_imem_addr", imem_addr, 32'd40);
        stepClock();

        $display("[TB] interrupt entry over branch");
        applyStimulus(0, 1, 1, 32'd20, 0, 1);
        stepClock();
        applyStimulus(0, 1, 1, 32'd40, 1, 1);
        checkOutput("irq_addr", address, INT_VEC);
        stepClock();
        ack_count = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, 0, 1, 1);
            if (int_ack) ack_count++;
            if (i == 0) begin
                checkOutput("irq_epc", epc, 32'd40);
                checkOutput("irq_ack", {31'b0, int_ack}, 32'h1);
            end
            stepClock();
        end
        checkOutput("irq_ack_count", ack_count, 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 1);
        stepClock();

        $display("[TB] asynchronous reset mid-wait");
        applyStimulus(0, 1, 0, 0, 0, 1);
        stepClock();
        decode_stall = 1'b0;
        imem_ready   = 1'b0;
        branch_taken = 1'b0;
        interrupt    = 1'b0;
        #1;
        checkOutput("wait_req", {31'b0, imem_req}, 32'h1);
        checkOutput("wait_valid", {31'b0, instr_valid}, 32'h1);
        doReset(32'd30);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("post_rst_idle_req", {31'b0, imem_req}, 32'h0);
        checkOutput("post_rst_idle_addr", address, 32'd30);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("post_rst_fetch_req", {31'b0, imem_req}, 32'h1);
        stepClock();

        $display("[TB] randomised traffic");
        intr_level = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 8) intr_level = ~intr_level;
            applyStimulus($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70,
                          $urandom_range(0, 99) < 10, $urandom, intr_level, 0);
            stepClock();
        end

        repeat (2) @(posedge clock);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Drives the next-PC `address` into the PC register and fetches the instruction at the current `programCounter` from instruction memory over a req/ready handshake.
- Forms the other half of the PC loop: the PC register loads `address` on every clock edge, so this block holds `address = programCounter` whenever it does not advance.
- Next-PC priority: interrupt vector, then branch redirect, then sequential +1.
- All addresses are word indices.

Parameters:
ADDR_W, 32, address/PC width
INSTR_W, 32, instruction width
INT_VECTOR, 8, word address loaded on interrupt entry

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
programCounter  in  ADDR_W  current PC from the PC register
address  out  ADDR_W  next PC to the PC register (combinational)
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, always equal to programCounter
imem_ready  in  1  memory response valid; meaningful only while imem_req=1
imem_data  in  INSTR_W  fetched instruction
instruction  out  INSTR_W  registered instruction to decode
instr_valid  out  1  instruction holds an unconsumed word
decode_stall  in  1  decode cannot accept this cycle
branch_taken  in  1  single-cycle redirect from execute
branch_target  in  ADDR_W  redirect target
interrupt  in  1  interrupt request; rising edge triggers
int_ack  out  1  one-cycle pulse on interrupt entry
epc  out  ADDR_W  saved return address

Behaviour:
- Reset (asynchronous, immediate, no clock needed):
  - state=IDLE; instruction=0, instr_valid=0, epc=0, int_ack=0.
  - Interrupt edge register cleared; imem_req=0.
  - address=0 while reset is high.
- States: IDLE, FETCH, HOLD, IRQ.
- IDLE: the first clock after reset deasserts moves to FETCH. address=programCounter; imem_req=0.
- Consumption: occurs in a cycle where instr_valid=1 and decode_stall=0.
- Slot free: instr_valid=0 or consumption this cycle.
- FETCH:
  - imem_req=1 only when the slot is free.
  - If instr_valid=1 and decode_stall=1: imem_req=0, address=programCounter, next state HOLD.
  - If imem_req=1 and imem_ready=1 (accepted): instruction<=imem_data, instr_valid<=1, address=programCounter+1 (mod 2^ADDR_W; 0xFFFFFFFF -> 0x00000000), stay FETCH.
  - Otherwise (waiting): address=programCounter. instr_valid clears if consumption occurs.
- HOLD:
  - imem_req=0; address=programCounter; instruction stable.
  - When decode_stall=0: the instruction is consumed, instr_valid<=0, next state FETCH.
- Branch (branch_taken=1 in FETCH or HOLD):
  - address=branch_target.
  - instr_valid<=0 (flush).
  - Any imem_ready response in the same cycle is discarded; instruction is not updated.
  - Next state FETCH.
- Interrupt:
  - Edge detect: irq_edge = interrupt & ~interrupt_q; interrupt_q is registered every cycle.
  - A held level never retriggers.
  - An edge seen in IDLE or IRQ is ignored.
- Interrupt entry (irq_edge in FETCH or HOLD):
  - Overrides branch and sequential next-PC.
  - address=INT_VECTOR.
  - epc<=branch_taken ? branch_target : programCounter.
  - instr_valid<=0; same-cycle response discarded.
  - Next state IRQ.
- IRQ:
  - int_ack=1 for exactly this cycle.
  - imem_req=0; address=programCounter.
  - Next state FETCH.
- imem_addr=programCounter in every state.
- Outputs are valid the cycle they are driven; response latency is arbitrary (0..N cycles of imem_ready low).
- Throughput: 1 instruction per cycle when imem_ready=1 and decode_stall=0.

Test Plan:
1. Release reset with PC register loading 14; imem_ready=1 every cycle, imem_data=0xA000_0000+PC -> address sequence 14,15,16,17 on consecutive cycles; instruction 0xA000000E, 0xA000000F...; instr_valid=1 from the first accepted cycle.
2. programCounter=0xFFFFFFFF (progr=00 reset value), imem_ready=1 -> address=0x00000000; instruction=imem_data.
3. Valid instruction held with decode_stall=1 for 3 cycles -> imem_req=0, address==programCounter, instruction unchanged for all 3 cycles; stall drop -> instr_valid 0, fetch resumes.
4. In FETCH with PC=20, imem_ready=1 and branch_taken=1, target 40 -> address=40; next cycle instr_valid=0, instruction unchanged; following fetch uses imem_addr=40.
5. interrupt rises with PC=20 and simultaneous branch_taken, target 40 -> address=8, epc=40; int_ack high exactly 1 cycle; interrupt held high 10 cycles -> no second int_ack.
6. Assert reset mid-wait (imem_req=1, imem_ready=0), between clock edges -> instr_valid, imem_req, int_ack, instruction, epc all 0 immediately, before the next edge; release -> IDLE then FETCH.
